// File: rtl/mul_pkg.sv
// Multiply op encodings and the result-select function shared with decode.
package mul_pkg;

  localparam int MUL_OP_W = 2;

  localparam logic [MUL_OP_W-1:0] MUL_OP_W_LO = 2'b00;
  localparam logic [MUL_OP_W-1:0] MUL_OP_H    = 2'b01;
  localparam logic [MUL_OP_W-1:0] MUL_OP_HU   = 2'b10;

  // High half for both mulh flavours; the reserved encoding falls back to the low half.
  function automatic logic [31:0] mul_select(input logic [MUL_OP_W-1:0] op,
                                             input logic [63:0] product);
    logic [31:0] res;
    res = product[31:0];
    if (op == MUL_OP_H || op == MUL_OP_HU) begin
      res = product[63:32];
    end
    return res;
  endfunction

endpackage

// File: rtl/mul_res_fifo.sv
// In-order result buffer: DEPTH entries of {data, dest, pc} with count and flush.
module mul_res_fifo
  import mul_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       push,
  input  logic [31:0]                push_data,
  input  logic [4:0]                 push_dest,
  input  logic [PC_W-1:0]            push_pc,
  input  logic                       pop,
  output logic [31:0]                head_data,
  output logic [4:0]                 head_dest,
  output logic [PC_W-1:0]            head_pc,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]     data_mem [DEPTH];
  logic [4:0]      dest_mem [DEPTH];
  logic [PC_W-1:0] pc_mem   [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        dest_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push) begin
        data_mem[wr_ptr_reg] <= push_data;
        dest_mem[wr_ptr_reg] <= push_dest;
        pc_mem[wr_ptr_reg]   <= push_pc;
        wr_ptr_reg           <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + CW'(1);
        2'b01:   cnt_reg <= cnt_reg - CW'(1);
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  assign head_data = data_mem[rd_ptr_reg];
  assign head_dest = dest_mem[rd_ptr_reg];
  assign head_pc   = pc_mem[rd_ptr_reg];
  assign full      = (cnt_reg == CW'(DEPTH));
  assign count     = cnt_reg;

endmodule

// File: rtl/mul_result_stage.sv
// Collect stage after the multiplier: selects the 32-bit result and buffers it toward MEM.
module mul_result_stage
  import mul_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MUL_OP_W-1:0]        in_op,
  input  logic [4:0]                 in_dest,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       mul_signed,
  input  logic [63:0]                mul_result,
  input  logic                       mul_complete,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [4:0]                 out_dest,
  output logic [PC_W-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0] occ_cnt
);

  logic            push;
  logic            pop;
  logic            full;
  logic [31:0]     head_data;
  logic [4:0]      head_dest;
  logic [PC_W-1:0] head_pc;

  assign mul_signed = (in_op == MUL_OP_H);

  // in_ready depends only on local state, never on out_ready.
  assign in_ready  = resetn && !flush && !full;
  assign push      = in_valid && mul_complete && in_ready;
  assign out_valid = resetn && !flush && (occ_cnt != '0);
  assign pop       = out_valid && out_ready;

  mul_res_fifo #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .push      (push),
    .push_data (mul_select(in_op, mul_result)),
    .push_dest (in_dest),
    .push_pc   (in_pc),
    .pop       (pop),
    .head_data (head_data),
    .head_dest (head_dest),
    .head_pc   (head_pc),
    .full      (full),
    .count     (occ_cnt)
  );

  // Outputs read as zero while reset is held.
  assign out_data = resetn ? head_data : '0;
  assign out_dest = resetn ? head_dest : '0;
  assign out_pc   = resetn ? head_pc   : '0;

endmodule

// File: tb/tb_mul_result_stage.sv
// Directed bench for mul_result_stage: vector table plus multi-cycle handshake sequences.
module tb_mul_result_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [4:0]  in_dest;
  logic [31:0] in_pc;
  logic        mul_signed;
  logic [63:0] mul_result;
  logic        mul_complete;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_dest;
  logic [31:0] out_pc;
  logic [1:0]  occ_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_result_stage #(.DEPTH(2), .PC_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_dest      (in_dest),
    .in_pc        (in_pc),
    .mul_signed   (mul_signed),
    .mul_result   (mul_result),
    .mul_complete (mul_complete),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_dest     (out_dest),
    .out_pc       (out_pc),
    .occ_cnt      (occ_cnt)
  );

  typedef struct {
    logic [1:0]  op;
    logic [63:0] res;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] exp_data;
    logic        exp_signed;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [63:0] res, input logic [4:0] dest,
                       input logic [31:0] pc);
    in_valid     = 1'b1;
    mul_complete = 1'b1;
    in_op        = op;
    mul_result   = res;
    in_dest      = dest;
    in_pc        = pc;
  endtask

  initial begin
    vecs[0] = '{2'b00, 64'h0000_0001_FFFF_FFFE, 5'd5,  32'h1C00_0000, 32'hFFFF_FFFE, 1'b0};
    vecs[1] = '{2'b01, 64'h4000_0000_0000_0000, 5'd6,  32'h1C00_0004, 32'h4000_0000, 1'b1};
    vecs[2] = '{2'b10, 64'hFFFF_FFFE_0000_0001, 5'd7,  32'h1C00_0008, 32'hFFFF_FFFE, 1'b0};
    vecs[3] = '{2'b11, 64'h1234_5678_9ABC_DEF0, 5'd31, 32'h1C00_000C, 32'h9ABC_DEF0, 1'b0};
    vecs[4] = '{2'b01, 64'hDEAD_BEEF_0000_0000, 5'd1,  32'h1C00_0010, 32'hDEAD_BEEF, 1'b1};

    // Reset held with in_valid asserted
    resetn = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(2'b00, 64'h0000_0000_1111_1111, 5'd9, 32'h0000_0040);
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_occ", occ_cnt, 0);
    check("rst_out_data", out_data, 0);
    tick();
    in_valid = 1'b0;
    resetn = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);
    tick();
    check("rel_out_valid", out_valid, 0);
    check("rel_occ", occ_cnt, 0);

    // Table-driven single-entry vectors
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].op, vecs[i].res, vecs[i].dest, vecs[i].pc);
      out_ready = 1'b0;
      #1;
      check($sformatf("v%0d_signed", i), mul_signed, vecs[i].exp_signed);
      check($sformatf("v%0d_nobypass", i), out_valid, 0);
      tick();
      in_valid = 1'b0;
      check($sformatf("v%0d_valid", i), out_valid, 1);
      check($sformatf("v%0d_data", i), out_data, vecs[i].exp_data);
      check($sformatf("v%0d_dest", i), out_dest, vecs[i].dest);
      check($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
      check($sformatf("v%0d_occ", i), occ_cnt, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check($sformatf("v%0d_drain", i), occ_cnt, 0);
    end

    // Full stall and in-order drain
    drive(2'b00, 64'h0000_0000_AAAA_0001, 5'd10, 32'h100); tick();
    drive(2'b00, 64'h0000_0000_BBBB_0002, 5'd11, 32'h104); tick();
    drive(2'b00, 64'h0000_0000_CCCC_0003, 5'd12, 32'h108); #1;
    check("full_occ", occ_cnt, 2);
    check("full_in_ready", in_ready, 0);
    tick();
    check("full_stall_occ", occ_cnt, 2);
    out_ready = 1'b1; #1;
    check("full_no_comb_ready", in_ready, 0);
    check("order_a", out_data, 32'hAAAA_0001);
    tick();
    check("c_accept_ready", in_ready, 1);
    check("order_b", out_data, 32'hBBBB_0002);
    tick();
    in_valid = 1'b0;
    check("c_accept_occ", occ_cnt, 1);
    check("order_c", out_data, 32'hCCCC_0003);
    check("order_c_dest", out_dest, 12);
    tick();
    out_ready = 1'b0;
    check("drain_occ", occ_cnt, 0);

    // Flush with entries held and an incoming op
    drive(2'b00, 64'h0000_0000_0000_00A1, 5'd2, 32'h200); tick();
    drive(2'b00, 64'h0000_0000_0000_00A2, 5'd3, 32'h204); tick();
    drive(2'b10, 64'h0000_00A3_0000_0000, 5'd4, 32'h208);
    flush = 1'b1; out_ready = 1'b1; #1;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_occ", occ_cnt, 0);
    check("flush_out_valid_after", out_valid, 0);
    out_ready = 1'b0;

    // Simultaneous enqueue and dequeue
    drive(2'b00, 64'h0000_0000_0000_0D01, 5'd20, 32'h300); tick();
    drive(2'b01, 64'h0000_0D02_0000_0000, 5'd21, 32'h304);
    out_ready = 1'b1; #1;
    check("simul_head_first", out_data, 32'h0000_0D01);
    tick();
    in_valid = 1'b0;
    check("simul_occ", occ_cnt, 1);
    check("simul_head_second", out_data, 32'h0000_0D02);
    check("simul_pc", out_pc, 32'h304);
    tick();
    check("simul_drain", occ_cnt, 0);

    // in_valid without mul_complete
    drive(2'b00, 64'h0000_0000_0000_0E01, 5'd22, 32'h400);
    mul_complete = 1'b0;
    tick();
    in_valid = 1'b0;
    check("nocomplete_occ", occ_cnt, 0);
    check("nocomplete_valid", out_valid, 0);

    // Reset mid-operation drops held entries
    out_ready = 1'b0;
    drive(2'b00, 64'h0000_0000_0000_0F01, 5'd23, 32'h500); tick();
    in_valid = 1'b0;
    resetn = 1'b0; #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    tick();
    resetn = 1'b1; #1;
    check("midrst_occ", occ_cnt, 0);
    check("midrst_valid_after", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Guard against a hang if something stalls the clocked sequence.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, %0d compares so far", n_vec);
    $fatal(1, "timeout");
  end

endmodule
